// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake and a two-entry skid buffer.
// Holds up to two entries in strict FIFO order and gates control to zero on bubbles.
module pipe_skid_stage #(
    parameter int unsigned DATA_W = 72,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   w_main_data_d;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [CTRL_W-1:0]   w_main_ctrl_d;
    logic [DATA_W-1:0]   r_skid_data;
    logic [DATA_W-1:0]   w_skid_data_d;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [CTRL_W-1:0]   w_skid_ctrl_d;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    w_stall_cnt_d;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_accept;
    logic                w_issue;
    logic                w_stalled;

    // Handshake decode depends on registered state only, never on out_ready.
    assign w_in_ready  = (r_state != StTwo);
    assign w_out_valid = (r_state != StEmpty);
    assign w_accept    = in_valid & w_in_ready;
    assign w_issue     = w_out_valid & out_ready;
    assign w_stalled   = w_out_valid & ~out_ready;

    always_comb begin
        w_state_d     = r_state;
        w_main_data_d = r_main_data;
        w_main_ctrl_d = r_main_ctrl;
        w_skid_data_d = r_skid_data;
        w_skid_ctrl_d = r_skid_ctrl;

        if (flush) begin
            // Data is cleared too so stale payload cannot linger on out_data.
            w_state_d     = StEmpty;
            w_main_data_d = '0;
            w_main_ctrl_d = '0;
            w_skid_data_d = '0;
            w_skid_ctrl_d = '0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_main_data_d = in_data;
                        w_main_ctrl_d = in_ctrl;
                        w_state_d     = StOne;
                    end
                end
                StOne: begin
                    if (w_issue && w_accept) begin
                        w_main_data_d = in_data;
                        w_main_ctrl_d = in_ctrl;
                    end else if (w_issue) begin
                        w_state_d = StEmpty;
                    end else if (w_accept) begin
                        w_skid_data_d = in_data;
                        w_skid_ctrl_d = in_ctrl;
                        w_state_d     = StTwo;
                    end
                end
                StTwo: begin
                    if (w_issue) begin
                        w_main_data_d = r_skid_data;
                        w_main_ctrl_d = r_skid_ctrl;
                        w_state_d     = StOne;
                    end
                end
                default: begin
                    w_state_d = StEmpty;
                end
            endcase
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt;
        if (clr_cnt) begin
            w_stall_cnt_d = '0;
        end else if (w_stalled && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StEmpty;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_main_data <= w_main_data_d;
            r_main_ctrl <= w_main_ctrl_d;
            r_skid_data <= w_skid_data_d;
            r_skid_ctrl <= w_skid_ctrl_d;
            r_stall_cnt <= w_stall_cnt_d;
        end
    end

    always_comb begin
        occupancy = 2'd0;
        unique case (r_state)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    // Bubble: an empty stage must never present MEM/WB side effects.
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign stall_cnt = r_stall_cnt;

    a_state_legal : assert property (@(posedge clk) disable iff (rst) r_state != 2'd3);

endmodule
